calc_operator: RTL and testbench



---
 rtl/calc_operator_if.sv | 37 +++
 rtl/calc_operator.sv | 133 +++++++++++++
 tb/tb_calc_operator.sv | 346 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/calc_operator_if.sv
// Stream bundle for calc_operator: operand A/B inputs, result output and the tlast error flag.
// slave is the operator's own view; master is the environment that feeds and drains it.
interface calc_operator_if #(
  parameter int DATA_W = 32
);
  logic [DATA_W-1:0] s_a_tdata;
  logic              s_a_tvalid;
  logic              s_a_tlast;
  logic              s_a_tready;
  logic [DATA_W-1:0] s_b_tdata;
  logic              s_b_tvalid;
  logic              s_b_tlast;
  logic              s_b_tready;
  logic [DATA_W-1:0] m_result_tdata;
  logic              m_result_tvalid;
  logic              m_result_tlast;
  logic              m_result_tready;
  logic              err_tlast;

  modport slave (
    input  s_a_tdata, s_a_tvalid, s_a_tlast,
           s_b_tdata, s_b_tvalid, s_b_tlast,
           m_result_tready,
    output s_a_tready, s_b_tready,
           m_result_tdata, m_result_tvalid, m_result_tlast,
           err_tlast
  );

  modport master (
    output s_a_tdata, s_a_tvalid, s_a_tlast,
           s_b_tdata, s_b_tvalid, s_b_tlast,
           m_result_tready,
    input  s_a_tready, s_b_tready,
           m_result_tdata, m_result_tvalid, m_result_tlast,
           err_tlast
  );
endinterface

// File: rtl/calc_operator.sv
// Joins A/B operand streams, applies add/sub/mul (OP) and buffers results; define CALC_OPERATOR_SAT_EN to saturate instead of wrap.
// Result valid LATENCY edges after acceptance; operands are taken only as a pair and only while credit remains.
module calc_operator #(
  parameter int DATA_W     = 32,
  parameter int OP         = 0,
  parameter int LATENCY    = 3,
  parameter int FIFO_DEPTH = 8
) (
  input  logic           aclk,
  input  logic           areset,
  calc_operator_if.slave io
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = $clog2(FIFO_DEPTH) + 2;

  logic               credit;
  logic               accept;
  logic               push;
  logic               pop;
  logic [DATA_W-1:0]  op_res;

  logic [LATENCY-1:0] pipe_vld_q, pipe_vld_d;
  logic [LATENCY-1:0] pipe_last_q, pipe_last_d;
  logic [DATA_W-1:0]  pipe_dat_q [LATENCY];
  logic [DATA_W-1:0]  pipe_dat_d [LATENCY];

  logic [DATA_W:0]    mem_q [FIFO_DEPTH];
  logic [DATA_W:0]    mem_d [FIFO_DEPTH];
  logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]   in_flight_q, in_flight_d;
  logic [CNT_W-1:0]   fifo_count_q, fifo_count_d;
  logic               err_tlast_q, err_tlast_d;

  // Every accepted pair owns a buffer slot from acceptance on, so the pipeline never has to stall.
  assign credit        = (in_flight_q + fifo_count_q) < CNT_W'(FIFO_DEPTH);
  assign accept        = ~areset & io.s_a_tvalid & io.s_b_tvalid & credit;
  assign io.s_a_tready = accept;
  assign io.s_b_tready = accept;

  assign push               = pipe_vld_q[LATENCY-1];
  assign io.m_result_tvalid = (fifo_count_q != '0);
  assign pop                = io.m_result_tvalid & io.m_result_tready;
  assign io.m_result_tdata  = io.m_result_tvalid ? mem_q[rd_ptr_q][DATA_W-1:0] : '0;
  assign io.m_result_tlast  = io.m_result_tvalid & mem_q[rd_ptr_q][DATA_W];
  assign io.err_tlast       = err_tlast_q;

`ifdef CALC_OPERATOR_SAT_EN
  logic signed [2*DATA_W-1:0] a_ext;
  logic signed [2*DATA_W-1:0] b_ext;
  logic signed [2*DATA_W-1:0] wide;

  always_comb begin
    a_ext = {{DATA_W{io.s_a_tdata[DATA_W-1]}}, io.s_a_tdata};
    b_ext = {{DATA_W{io.s_b_tdata[DATA_W-1]}}, io.s_b_tdata};
    case (OP)
      0:       wide = a_ext + b_ext;
      1:       wide = a_ext - b_ext;
      default: wide = a_ext * b_ext;
    endcase
    // Overflow whenever the bits above the result's sign are not all copies of the true sign.
    if (!wide[2*DATA_W-1] && (wide[2*DATA_W-2:DATA_W-1] != '0)) begin
      op_res = {1'b0, {(DATA_W-1){1'b1}}};
    end else if (wide[2*DATA_W-1] && (wide[2*DATA_W-2:DATA_W-1] != '1)) begin
      op_res = {1'b1, {(DATA_W-1){1'b0}}};
    end else begin
      op_res = wide[DATA_W-1:0];
    end
  end
`else
  always_comb begin
    case (OP)
      0:       op_res = io.s_a_tdata + io.s_b_tdata;
      1:       op_res = io.s_a_tdata - io.s_b_tdata;
      default: op_res = io.s_a_tdata * io.s_b_tdata;
    endcase
  end
`endif

  always_comb begin
    pipe_vld_d     = pipe_vld_q;
    pipe_last_d    = pipe_last_q;
    pipe_dat_d     = pipe_dat_q;
    pipe_vld_d[0]  = accept;
    pipe_last_d[0] = io.s_a_tlast;
    pipe_dat_d[0]  = op_res;
    for (int i = 1; i < LATENCY; i++) begin
      pipe_vld_d[i]  = pipe_vld_q[i-1];
      pipe_last_d[i] = pipe_last_q[i-1];
      pipe_dat_d[i]  = pipe_dat_q[i-1];
    end

    mem_d = mem_q;
    if (push) begin
      mem_d[wr_ptr_q] = {pipe_last_q[LATENCY-1], pipe_dat_q[LATENCY-1]};
    end
    wr_ptr_d     = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d     = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    in_flight_d  = in_flight_q + CNT_W'(accept) - CNT_W'(push);
    fifo_count_d = fifo_count_q + CNT_W'(push) - CNT_W'(pop);
    err_tlast_d  = err_tlast_q | (accept & (io.s_a_tlast ^ io.s_b_tlast));
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      pipe_vld_q   <= '0;
      pipe_last_q  <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      in_flight_q  <= '0;
      fifo_count_q <= '0;
      err_tlast_q  <= 1'b0;
    end else begin
      pipe_vld_q   <= pipe_vld_d;
      pipe_last_q  <= pipe_last_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      in_flight_q  <= in_flight_d;
      fifo_count_q <= fifo_count_d;
      err_tlast_q  <= err_tlast_d;
    end
  end

  // Payload storage carries no reset; only the valid/count state decides what is visible.
  always_ff @(posedge aclk) begin
    pipe_dat_q <= pipe_dat_d;
    mem_q      <= mem_d;
  end

  push_into_full_buffer: assert property (@(posedge aclk) disable iff (areset)
    !(push && (fifo_count_q == CNT_W'(FIFO_DEPTH))));

endmodule

// File: tb/tb_calc_operator.sv
// Add, sub and mul instances share one stimulus stream; each cycle their outputs are compared
// against a queue model holding accepted pairs, their due cycle and full-precision arithmetic.
`timescale 1ns/1ps
module tb_calc_operator;
  localparam int W     = 32;
  localparam int LAT   = 3;
  localparam int DEPTH = 8;

  logic aclk = 1'b0;
  logic areset;
  always #5 aclk = ~aclk;

  calc_operator_if #(.DATA_W(W)) if_add ();
  calc_operator_if #(.DATA_W(W)) if_sub ();
  calc_operator_if #(.DATA_W(W)) if_mul ();

  assign if_sub.s_a_tdata       = if_add.s_a_tdata;
  assign if_sub.s_a_tvalid      = if_add.s_a_tvalid;
  assign if_sub.s_a_tlast       = if_add.s_a_tlast;
  assign if_sub.s_b_tdata       = if_add.s_b_tdata;
  assign if_sub.s_b_tvalid      = if_add.s_b_tvalid;
  assign if_sub.s_b_tlast       = if_add.s_b_tlast;
  assign if_sub.m_result_tready = if_add.m_result_tready;
  assign if_mul.s_a_tdata       = if_add.s_a_tdata;
  assign if_mul.s_a_tvalid      = if_add.s_a_tvalid;
  assign if_mul.s_a_tlast       = if_add.s_a_tlast;
  assign if_mul.s_b_tdata       = if_add.s_b_tdata;
  assign if_mul.s_b_tvalid      = if_add.s_b_tvalid;
  assign if_mul.s_b_tlast       = if_add.s_b_tlast;
  assign if_mul.m_result_tready = if_add.m_result_tready;

  calc_operator #(.DATA_W(W), .OP(0), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut_add (
    .aclk(aclk), .areset(areset), .io(if_add.slave));
  calc_operator #(.DATA_W(W), .OP(1), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut_sub (
    .aclk(aclk), .areset(areset), .io(if_sub.slave));
  calc_operator #(.DATA_W(W), .OP(2), .LATENCY(LAT), .FIFO_DEPTH(DEPTH)) dut_mul (
    .aclk(aclk), .areset(areset), .io(if_mul.slave));

  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         last;
    int           due;
  } pend_t;

  pend_t pend[$];
  int    cyc    = 0;
  int    checks = 0;
  int    errors = 0;

  function automatic logic [W-1:0] ref_op(int op, logic [W-1:0] a, logic [W-1:0] b);
    longint sa, sb, r;
    sa = {{32{a[W-1]}}, a};
    sb = {{32{b[W-1]}}, b};
    case (op)
      0:       r = sa + sb;
      1:       r = sa - sb;
      default: r = sa * sb;
    endcase
`ifdef CALC_OPERATOR_SAT_EN
    if (r > 64'sd2147483647) return 32'h7FFF_FFFF;
    if (r < -64'sd2147483648) return 32'h8000_0000;
`endif
    return r[W-1:0];
  endfunction

  // Outstanding results (accepted, not yet popped) bound acceptance; pops count from the next cycle.
  function automatic logic exp_rdy();
    return !areset && if_add.s_a_tvalid && if_add.s_b_tvalid && (pend.size() < DEPTH);
  endfunction

  function automatic logic exp_vld();
    return (pend.size() > 0) && (pend[0].due <= cyc);
  endfunction

  function automatic logic [W+1:0] seg(logic v, logic [W-1:0] d, logic l);
    return v ? {1'b1, d, l} : '0;
  endfunction

  function automatic logic [3*W+5:0] obs_vec();
    return {seg(if_add.m_result_tvalid, if_add.m_result_tdata, if_add.m_result_tlast),
            seg(if_sub.m_result_tvalid, if_sub.m_result_tdata, if_sub.m_result_tlast),
            seg(if_mul.m_result_tvalid, if_mul.m_result_tdata, if_mul.m_result_tlast)};
  endfunction

  function automatic logic [3*W+5:0] exp_vec();
    if (!exp_vld()) return '0;
    return {seg(1'b1, ref_op(0, pend[0].a, pend[0].b), pend[0].last),
            seg(1'b1, ref_op(1, pend[0].a, pend[0].b), pend[0].last),
            seg(1'b1, ref_op(2, pend[0].a, pend[0].b), pend[0].last)};
  endfunction

  task automatic drive(input logic av, input logic bv, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic al, input logic bl, input logic rdy);
    if_add.s_a_tvalid      = av;
    if_add.s_b_tvalid      = bv;
    if_add.s_a_tdata       = a;
    if_add.s_b_tdata       = b;
    if_add.s_a_tlast       = al;
    if_add.s_b_tlast       = bl;
    if_add.m_result_tready = rdy;
    @(negedge aclk);
  endtask

  // A pair seen acceptable at this sample is taken on the next edge and shows LAT edges after that.
  task automatic advance();
    logic  acc, pop;
    pend_t p;
    acc = exp_rdy();
    pop = exp_vld() && if_add.m_result_tready;
    if (areset) begin
      pend.delete();
    end else begin
      if (pop) void'(pend.pop_front());
      if (acc) begin
        p.a = if_add.s_a_tdata; p.b = if_add.s_b_tdata;
        p.last = if_add.s_a_tlast; p.due = cyc + LAT + 1;
        pend.push_back(p);
      end
    end
    cyc++;
    @(posedge aclk);
    #1;
  endtask

  task automatic test_reset();
    areset = 1'b1;
    drive(1, 1, 32'd3, 32'd4, 1, 0, 1);
    checks++;
    if ({if_add.s_a_tready, if_add.s_b_tready} !== 2'b00) begin
      errors++; $display("FAIL rst_tready got=%b want=00", {if_add.s_a_tready, if_add.s_b_tready});
    end
    advance();
    drive(1, 1, 32'd3, 32'd4, 1, 0, 1);
    checks++;
    if ({if_add.m_result_tvalid, if_add.m_result_tdata, if_add.m_result_tlast, if_add.err_tlast} !== '0) begin
      errors++; $display("FAIL rst_outputs got v=%b d=%h l=%b e=%b want all zero", if_add.m_result_tvalid,
                         if_add.m_result_tdata, if_add.m_result_tlast, if_add.err_tlast);
    end
    advance();
    areset = 1'b0;
  endtask

  task automatic test_basic();
    logic [W-1:0] ta [6];
    logic [W-1:0] tb [6];
    logic [W-1:0] want;
    ta = '{32'd5, 32'h7FFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFD, 32'h4000_0000, 32'hFFFF_FFFF};
    tb = '{32'd7, 32'd1,         32'd1,         32'd4,         32'd2,         32'hFFFF_FFFF};
`ifdef CALC_OPERATOR_SAT_EN
    want = 32'h7FFF_FFFF;
`else
    want = 32'h8000_0000;
`endif
    for (int i = 0; i < 6; i++) begin
      drive(1, 1, ta[i], tb[i], i[0] == 1'b0, i[0] == 1'b0, 1);
      checks++;
      if ({if_add.s_a_tready, if_add.s_b_tready} !== 2'b11) begin
        errors++; $display("FAIL basic_accept pair=%0d got=%b want=11", i, {if_add.s_a_tready, if_add.s_b_tready});
      end
      advance();
      for (int k = 0; k <= LAT; k++) begin
        drive(0, 0, '0, '0, 0, 0, 1);
        checks++;
        if (obs_vec() !== exp_vec()) begin
          errors++; $display("FAIL basic_out pair=%0d k=%0d got=%h want=%h", i, k, obs_vec(), exp_vec());
        end
        if (i == 0 && k == LAT) begin
          checks++;
          if ({if_add.m_result_tvalid, if_add.m_result_tdata, if_add.m_result_tlast} !== {1'b1, 32'd12, 1'b1}) begin
            errors++; $display("FAIL add_5_7 got v=%b d=%0d l=%b want v=1 d=12 l=1",
                               if_add.m_result_tvalid, if_add.m_result_tdata, if_add.m_result_tlast);
          end
        end
        if (i == 1 && k == LAT) begin
          checks++;
          if (if_add.m_result_tdata !== want) begin
            errors++; $display("FAIL add_overflow got=%h want=%h", if_add.m_result_tdata, want);
          end
        end
        advance();
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      logic l;
      l = 1'($urandom_range(0, 1));
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 3) != 0, $urandom, $urandom, l, l,
            $urandom_range(0, 4) != 0);
      checks++;
      if ({if_add.s_a_tready, if_add.s_b_tready} !== {2{exp_rdy()}}) begin
        errors++; $display("FAIL rand_tready cyc=%0d got=%b want=%b", cyc,
                           {if_add.s_a_tready, if_add.s_b_tready}, {2{exp_rdy()}});
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rand_out cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      advance();
    end
    for (int n = 0; n < 16; n++) begin
      drive(0, 0, '0, '0, 0, 0, 1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL rand_drain cyc=%0d got=%h want=%h", cyc, obs_vec(), exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_backpressure();
    int next = 0, got = 0, first = -1, last_c = -1;
    for (int n = 0; n < 12; n++) begin
      drive(1, 1, W'(next), W'(next + 1), 0, 0, 0);
      checks++;
      if ({if_add.s_a_tready, if_add.s_b_tready} !== {2{exp_rdy()}}) begin
        errors++; $display("FAIL bp_hold_tready n=%0d got=%b want=%b", n,
                           {if_add.s_a_tready, if_add.s_b_tready}, {2{exp_rdy()}});
      end
      if (if_add.s_a_tready === 1'b1) next++;
      advance();
    end
    checks++;
    if (next !== DEPTH) begin
      errors++; $display("FAIL bp_accepted got=%0d want=%0d", next, DEPTH);
    end
    for (int n = 0; n < 60 && got < 20; n++) begin
      drive(next < 20, next < 20, W'(next), W'(next + 1), 0, 0, 1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL bp_out n=%0d got=%h want=%h", n, obs_vec(), exp_vec());
      end
      if (if_add.m_result_tvalid === 1'b1) begin
        checks++;
        if (if_mul.m_result_tdata !== W'(got * (got + 1))) begin
          errors++; $display("FAIL bp_order idx=%0d got=%0d want=%0d", got, if_mul.m_result_tdata, got * (got + 1));
        end
        if (first < 0) first = n;
        last_c = n;
        got++;
      end
      if (if_add.s_a_tready === 1'b1) next++;
      advance();
    end
    checks++;
    if (got !== 20 || (last_c - first) !== 19) begin
      errors++; $display("FAIL bp_stream got results=%0d span=%0d want results=20 span=19", got, last_c - first);
    end
  endtask

  task automatic test_join();
    for (int n = 0; n <= 10; n++) begin
      drive(1, n == 10, 32'd9, 32'd11, 0, 0, 1);
      checks++;
      if ({if_add.s_a_tready, if_add.s_b_tready} !== ((n == 10) ? 2'b11 : 2'b00)) begin
        errors++; $display("FAIL join_tready n=%0d got=%b want=%b", n,
                           {if_add.s_a_tready, if_add.s_b_tready}, (n == 10) ? 2'b11 : 2'b00);
      end
      advance();
    end
    for (int n = 0; n < 6; n++) begin
      drive(0, 0, '0, '0, 0, 0, 1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL join_out n=%0d got=%h want=%h", n, obs_vec(), exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_tlast_err();
    drive(1, 1, 32'd1, 32'd2, 1, 0, 1);
    checks++;
    if (if_add.err_tlast !== 1'b0) begin
      errors++; $display("FAIL err_before got=%b want=0", if_add.err_tlast);
    end
    advance();
    for (int n = 0; n < 8; n++) begin
      drive(n < 3, n < 3, W'(n), W'(n), 0, 0, 1);
      checks++;
      if (if_add.err_tlast !== 1'b1) begin
        errors++; $display("FAIL err_sticky n=%0d got=%b want=1", n, if_add.err_tlast);
      end
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL err_out n=%0d got=%h want=%h", n, obs_vec(), exp_vec());
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    for (int n = 0; n < 5; n++) begin
      drive(1, 1, W'(100 + n), W'(n), 1, 1, 0);
      checks++;
      if (if_add.s_a_tready !== 1'b1) begin
        errors++; $display("FAIL mid_accept n=%0d got=%b want=1", n, if_add.s_a_tready);
      end
      advance();
    end
    drive(0, 0, '0, '0, 0, 0, 0);
    advance();
    drive(0, 0, '0, '0, 0, 0, 0);
    checks++;
    if (obs_vec() !== exp_vec()) begin
      errors++; $display("FAIL mid_buffered got=%h want=%h", obs_vec(), exp_vec());
    end
    areset = 1'b1;
    advance();
    areset = 1'b0;
    for (int n = 0; n < 10; n++) begin
      drive(n == 0, n == 0, 32'd7, 32'd6, 1, 1, 1);
      checks++;
      if (obs_vec() !== exp_vec()) begin
        errors++; $display("FAIL mid_after_reset n=%0d got=%h want=%h", n, obs_vec(), exp_vec());
      end
      checks++;
      if (if_add.err_tlast !== 1'b0) begin
        errors++; $display("FAIL mid_err_cleared n=%0d got=%b want=0", n, if_add.err_tlast);
      end
      advance();
    end
  endtask

  initial begin
    areset                 = 1'b1;
    if_add.s_a_tvalid      = 1'b0;
    if_add.s_b_tvalid      = 1'b0;
    if_add.s_a_tdata       = '0;
    if_add.s_b_tdata       = '0;
    if_add.s_a_tlast       = 1'b0;
    if_add.s_b_tlast       = 1'b0;
    if_add.m_result_tready = 1'b0;
    test_reset();
    test_basic();
    test_random();
    test_backpressure();
    test_join();
    test_tlast_err();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
